// File: rtl/dmem_access_unit_if.sv
// ----------------------------------------------------------------------------
// dmem_access_unit_if
// Single-outstanding req/ack data-memory bus.
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : word-aligned byte address
//   mem_wdata : lane-replicated store data
//   mem_be    : byte enables (bit i = byte lane i, little-endian)
//   mem_rdata : load data, valid while mem_ack = 1
//   mem_ack   : single-cycle completion pulse
// master = access unit, slave = memory.
// ----------------------------------------------------------------------------
interface dmem_access_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_access_unit.sv
// ----------------------------------------------------------------------------
// dmem_access_unit
// MEM-stage data-memory port. Turns the EX/MEM address/store data into a
// single request on the req/ack bus, formats byte/half/word accesses and
// stalls the pipeline until the access completes.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   MemReadM      load in MEM stage
//   MemWriteM     store in MEM stage (never together with MemReadM)
//   SizeM         00 byte, 01 half, 10/11 word
//   SignExtM      load sign-extends when 1
//   ALUResultM    byte address
//   WriteDataM    right-aligned store data
//   ReadDataM     formatted load data (registered)
//   MemStallM     stall request to the hazard unit
//   AddrErrM      misaligned-access pulse (combinational, IDLE only)
//   BusErrM       timeout pulse, asserted in DONE (0 without the option)
//   bus           req/ack memory bus, master side
//
// Optional feature: define DMEM_TIMEOUT_EN to abandon an access after
// TIMEOUT_CYCLES REQ cycles without mem_ack. Parameters TIMEOUT_CYCLES and
// CNT_W (2**CNT_W > TIMEOUT_CYCLES) only matter with that macro defined.
// ----------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      MemReadM,
  input  logic                      MemWriteM,
  input  logic [1:0]                SizeM,
  input  logic                      SignExtM,
  input  logic [31:0]               ALUResultM,
  input  logic [31:0]               WriteDataM,
  output logic [31:0]               ReadDataM,
  output logic                      MemStallM,
  output logic                      AddrErrM,
  output logic                      BusErrM,
  dmem_access_unit_if.master        bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t state, nextState;

  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memBe;

  // access attributes captured at issue, used when the ack returns
  logic [1:0]  sizeP1;
  logic        sextP1;
  logic [1:0]  laneP1;

  logic acc, misaligned, issue, complete, timeout;

  function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] storeData(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] loadFormat(input logic [1:0] size, input logic sext,
                                             input logic [1:0] a, input logic [31:0] rdata);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  bS;
    logic signed [15:0] hS;
    logic signed [31:0] ext;
    b  = rdata[{a, 3'b000} +: 8];
    h  = a[1] ? rdata[31:16] : rdata[15:0];
    bS = b;
    hS = h;
    ext = '0;
    case (size)
      2'b00: begin
        if (sext) ext = bS;
        else      ext = {24'b0, b};
      end
      2'b01: begin
        if (sext) ext = hS;
        else      ext = {16'b0, h};
      end
      default: ext = rdata;
    endcase
    return ext;
  endfunction

  assign acc        = MemReadM | MemWriteM;
  // size 11 is handled as a word, so SizeM[1] covers both word encodings
  assign misaligned = ((SizeM == 2'b01) && ALUResultM[0]) ||
                      (SizeM[1] && (ALUResultM[1:0] != 2'b00));

  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.mem_be    = memBe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    MemStallM = 1'b0;
    AddrErrM  = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (misaligned) begin
            // suppressed while reset is held so the pulse is clean after reset
            AddrErrM = rst;
          end else begin
            MemStallM = 1'b1;
            issue     = 1'b1;
            nextState = REQ;
          end
        end
      end
      REQ: begin
        MemStallM = 1'b1;
        if (bus.mem_ack) begin
          complete  = 1'b1;
          nextState = DONE;
        end else if (timeout) begin
          nextState = DONE;
        end
      end
      // DONE releases the pipeline; returning to IDLE unconditionally
      // gives exactly one issue decision per instruction.
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // ---- stage p1: bus request registers and load result ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memBe     <= 4'b0;
      memAddr   <= 32'b0;
      memWdata  <= 32'b0;
      ReadDataM <= 32'b0;
    end else if (issue) begin
      memReq   <= 1'b1;
      memWe    <= MemWriteM;
      memBe    <= byteEnable(SizeM, ALUResultM[1:0]);
      memAddr  <= {ALUResultM[31:2], 2'b00};
      memWdata <= storeData(SizeM, WriteDataM);
    end else if (complete) begin
      memReq <= 1'b0;
      memWe  <= 1'b0;
      memBe  <= 4'b0;
      if (!memWe) ReadDataM <= loadFormat(sizeP1, sextP1, laneP1, bus.mem_rdata);
    end else if (timeout) begin
      memReq <= 1'b0;
      memWe  <= 1'b0;
      memBe  <= 4'b0;
      if (!memWe) ReadDataM <= 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      sizeP1 <= SizeM;
      sextP1 <= SignExtM;
      laneP1 <= ALUResultM[1:0];
    end
  end

`ifdef DMEM_TIMEOUT_EN
  logic [CNT_W-1:0] toCnt;

  // Fires in the REQ cycle whose increment would reach TIMEOUT_CYCLES,
  // i.e. after TIMEOUT_CYCLES REQ cycles without ack. An ack wins.
  assign timeout = (state == REQ) && !bus.mem_ack &&
                   (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              toCnt <= '0;
    else if (issue)                        toCnt <= '0;
    else if ((state == REQ) && !bus.mem_ack) toCnt <= toCnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) BusErrM <= 1'b0;
    else      BusErrM <= timeout;
  end
`else
  assign timeout = 1'b0;
  assign BusErrM = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_dmem_access_unit
// Drives directed and random loads/stores through dmem_access_unit, acting as
// the memory on the req/ack bus, and compares every observable against a
// lane-arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM, SignExtM;
  logic [1:0]  SizeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        MemStallM, AddrErrM, BusErrM;

  int vecs = 0;
  int errs = 0;
  logic [31:0] lastRead = 32'b0;

  always #5 clk = ~clk;

  dmem_access_unit_if bus();

  dmem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .SizeM(SizeM), .SignExtM(SignExtM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .MemStallM(MemStallM), .AddrErrM(AddrErrM), .BusErrM(BusErrM),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---- reference model ----
  function automatic int nBytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic int baseLane(input logic [1:0] s, input logic [31:0] addr);
    int n = nBytes(s);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic logic [3:0] expBe(input logic [1:0] s, input logic [31:0] addr);
    logic [3:0] be = '0;
    int n = nBytes(s);
    int b = baseLane(s, addr);
    for (int i = 0; i < 4; i++) be[i] = (i >= b) && (i < b + n);
    return be;
  endfunction

  function automatic logic [31:0] expWdata(input logic [1:0] s, input logic [31:0] wd);
    logic [31:0] w;
    int n = nBytes(s);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] expLoad(input logic [1:0] s, input logic sx,
                                          input logic [31:0] addr, input logic [31:0] rd);
    int n = nBytes(s);
    longint v = (longint'(rd) >> (8 * baseLane(s, addr))) & ((64'd1 << (8 * n)) - 1);
    if (sx && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic clearInputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; SizeM = 2'b10; SignExtM = 1'b0;
    ALUResultM = 32'b0; WriteDataM = 32'b0;
  endtask

  // Starts and ends 1 time unit after a rising edge with the DUT in IDLE.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [1:0] size, input logic sx, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdata, input int waitC);
    int stalls = 0;
    bit mis = (addr % nBytes(size)) != 0;
    MemReadM = rd; MemWriteM = wr; SizeM = size; SignExtM = sx;
    ALUResultM = addr; WriteDataM = wd; bus.mem_ack = 1'b0;
    @(negedge clk);
    if (mis) begin
      chk({tag, ".addrErr"}, AddrErrM, 1'b1);
      chk({tag, ".stallMis"}, MemStallM, 1'b0);
      @(posedge clk); #1;
      chk({tag, ".noReq"}, bus.mem_req, 1'b0);
      clearInputs();
      return;
    end
    chk({tag, ".addrErrOk"}, AddrErrM, 1'b0);
    if (MemStallM) stalls++;
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, ".req"}, bus.mem_req, 1'b1);
    chk({tag, ".we"}, bus.mem_we, wr);
    chk({tag, ".addr"}, bus.mem_addr, {addr[31:2], 2'b00});
    chk({tag, ".be"}, bus.mem_be, expBe(size, addr));
    if (wr) chk({tag, ".wdata"}, bus.mem_wdata, expWdata(size, wd));
    for (int c = 0; c <= waitC; c++) begin
      if (c > 0) @(negedge clk);
      if (MemStallM) stalls++;
      if (c == waitC) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rdata;
      end
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
    end
    @(negedge clk);
    if (MemStallM) stalls++;
    if (rd) lastRead = expLoad(size, sx, addr, rdata);
    chk({tag, ".rdata"}, ReadDataM, lastRead);
    chk({tag, ".reqDrop"}, bus.mem_req, 1'b0);
    chk({tag, ".stallCycles"}, stalls, waitC + 2);
    chk({tag, ".busErr"}, BusErrM, 1'b0);
    @(posedge clk); #1;
    clearInputs();
  endtask

  task automatic idleCycle(input bit strayAck);
    clearInputs();
    ALUResultM = $urandom;
    bus.mem_ack = strayAck;
    bus.mem_rdata = $urandom;
    @(negedge clk);
    chk("idle.stall", MemStallM, 1'b0);
    chk("idle.addrErr", AddrErrM, 1'b0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("idle.noReq", bus.mem_req, 1'b0);
    chk("idle.rdataHeld", ReadDataM, lastRead);
  endtask

  initial begin
    int reqCycles;
    rst = 1'b0;
    clearInputs();
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'b0;
    @(negedge clk);
    chk("rst.req", bus.mem_req, 1'b0);
    chk("rst.we", bus.mem_we, 1'b0);
    chk("rst.be", bus.mem_be, 4'b0);
    chk("rst.addr", bus.mem_addr, 32'b0);
    chk("rst.wdata", bus.mem_wdata, 32'b0);
    chk("rst.rdata", ReadDataM, 32'b0);
    chk("rst.busErr", BusErrM, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // directed cases
    access("wordLoad", 1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    access("sbyteLoad", 1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h80112233, 0);
    chk("sbyteVal", ReadDataM, 32'hFFFFFF80);
    access("ubyteLoad", 1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h80112233, 1);
    chk("ubyteVal", ReadDataM, 32'h00000080);
    access("halfStore", 0, 1, 2'b01, 0, 32'h22, 32'h0000ABCD, 32'h12345678, 4);
    access("misWord", 1, 0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 0);
    access("rsvdSize", 1, 0, 2'b11, 0, 32'h44, 32'h0, 32'hCAFEF00D, 2);
    idleCycle(1'b1);

    // reset while in REQ, then a late ack must be ignored
    MemReadM = 1'b1; SizeM = 2'b10; ALUResultM = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstMid.reqBefore", bus.mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk("rstMid.reqDrop", bus.mem_req, 1'b0);
    chk("rstMid.rdata", ReadDataM, 32'b0);
    lastRead = 32'b0;
    clearInputs();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("rstMid.ackIgnored", ReadDataM, 32'b0);
    chk("rstMid.stall", MemStallM, 1'b0);
    chk("rstMid.noReq", bus.mem_req, 1'b0);
    @(posedge clk); #1;

    // long wait: timeout when enabled, indefinite wait otherwise
    MemReadM = 1'b1; SizeM = 2'b10; ALUResultM = 32'h40;
    @(posedge clk); #1;
    reqCycles = 0;
`ifdef DMEM_TIMEOUT_EN
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!bus.mem_req) break;
      reqCycles++;
      @(posedge clk); #1;
    end
    chk("timeout.reqCycles", reqCycles, 4);
    chk("timeout.busErr", BusErrM, 1'b1);
    chk("timeout.rdata", ReadDataM, 32'b0);
    chk("timeout.stall", MemStallM, 1'b0);
    lastRead = 32'b0;
    @(posedge clk); #1;
    clearInputs();
    @(negedge clk);
    chk("timeout.busErrPulse", BusErrM, 1'b0);
    @(posedge clk); #1;
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_req && MemStallM && !BusErrM) reqCycles++;
      @(posedge clk); #1;
    end
    chk("noTimeout.held", reqCycles, 20);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    lastRead = 32'h0BADF00D;
    chk("noTimeout.rdata", ReadDataM, lastRead);
    chk("noTimeout.busErr", BusErrM, 1'b0);
    chk("noTimeout.stall", MemStallM, 1'b0);
    @(posedge clk); #1;
    clearInputs();
`endif

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 3));
      logic [31:0] ad = $urandom;
      int kind = $urandom_range(0, 9);
      if ($urandom_range(0, 9) < 7) ad = ad & ~32'(nBytes(sz) - 1);
      if (kind == 0) idleCycle($urandom_range(0, 1) == 1);
      else access("rnd", kind < 6, kind >= 6, sz, 1'($urandom_range(0, 1)), ad,
                  $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- MEM-stage data-memory port. Consumes the EX/MEM outputs (ALUResultM as address, WriteDataM as store data) and produces ReadDataM for the MEM/WB register.
- Drives a single-outstanding req/ack memory bus.
- Formats byte, halfword and word accesses.
- Raises MemStallM to the hazard unit until an access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of REQ cycles waited for mem_ack (used only with DMEM_TIMEOUT_EN).
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- MemReadM  in  1  load in MEM stage.
- MemWriteM  in  1  store in MEM stage; never asserted together with MemReadM.
- SizeM  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is reserved and treated as word.
- SignExtM  in  1  load sign-extends (1) or zero-extends (0).
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data, right-aligned.
- ReadDataM  out  32  formatted load data, registered.
- MemStallM  out  1  stall request to the hazard unit.
- AddrErrM  out  1  misaligned-access pulse.
- BusErrM  out  1  timeout pulse (tied 0 without DMEM_TIMEOUT_EN).
- mem_req  out  1  bus request, registered.
- mem_we  out  1  write strobe, registered.
- mem_addr  out  32  word address {ALUResultM[31:2], 2'b00}, registered.
- mem_wdata  out  32  lane-replicated store data, registered.
- mem_be  out  4  byte enables, registered.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  completion; single-cycle pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadDataM = 0.
  - AddrErrM, BusErrM = 0; timeout counter = 0.
  - Reset mid-access drops mem_req immediately; the access is abandoned and a later ack is ignored.
- Access valid: acc = MemReadM | MemWriteM.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠00.
- States IDLE, REQ, DONE.
- IDLE:
  - acc and aligned → MemStallM=1 (combinational). Next edge: load mem_* registers, mem_req=1, go to REQ.
  - acc and misaligned → no request, MemStallM=0, AddrErrM=1 for that cycle (combinational), stay in IDLE.
  - no acc → MemStallM=0.
  - mem_ack seen in IDLE is ignored.
- REQ:
  - MemStallM=1; mem_* held stable.
  - On mem_ack: mem_req←0, mem_we←0, mem_be←0; load ReadDataM←format(mem_rdata) if read (store keeps the old ReadDataM); go to DONE.
  - mem_ack in the same cycle as entry into REQ is not possible, because the request becomes visible only in REQ.
- DONE:
  - MemStallM=0, so the pipeline advances on this edge; ReadDataM is valid for MEM/WB capture.
  - Next state IDLE unconditionally. This guarantees one IDLE decision per instruction, so a held instruction is never re-issued.
- Latency: minimum 3 cycles per access (IDLE, REQ with ack, DONE); each ack wait cycle adds 1.
- Byte enables (little-endian, a = addr[1:0]):
  - byte: be = 1<<a.
  - half: be = a[1] ? 1100 : 0011.
  - word: be = 1111.
- Store data:
  - byte: {4{WriteDataM[7:0]}}.
  - half: {2{WriteDataM[15:0]}}.
  - word: unchanged.
- Load formatting:
  - Select the byte lane a, or the half lane a[1].
  - Extend to 32 bits by SignExtM.
  - word: unchanged.
- Back-to-back accesses: DONE→IDLE→REQ, so each access costs ≥3 cycles. No pipelining of bus requests.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to REQ and increments each REQ cycle without ack.
  - When count == TIMEOUT_CYCLES with no ack: mem_req←0, BusErrM=1 for one cycle (registered, asserted in DONE), ReadDataM←32'h0 for loads, go to DONE.
  - An ack arriving in that same cycle wins: normal completion, no BusErrM.
- Undefined: no counter; REQ waits indefinitely; BusErrM tied 0.

Test Plan:
- Word load, addr 0x0000_0010, ack on first REQ cycle, mem_rdata 0xDEADBEEF → mem_addr 0x10, mem_be 1111, MemStallM high 2 cycles, ReadDataM 0xDEADBEEF in DONE, 3-cycle total.
- Signed byte load, addr 0x13, rdata 0x80112233 → be 1000, ReadDataM 0xFFFFFF80. Same with SignExtM=0 → 0x00000080.
- Half store, addr 0x22, WriteDataM 0x0000ABCD, ack after 4 wait cycles → mem_we=1, be 1100, wdata 0xABCDABCD, MemStallM high 6 cycles.
- Word load at addr 0x06 → AddrErrM=1 same cycle, mem_req never asserted, MemStallM=0.
- rst driven low while in REQ, then ack pulsed → mem_req 0 immediately, state IDLE, ack ignored, ReadDataM 0.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → mem_req drops after 4 REQ cycles, BusErrM one-cycle pulse, ReadDataM 0, pipeline released.
